eth1to4_xgmii_tx: RTL and testbench

//  Egress counterpart of the 4-port XGMII RX mux. Accepts a single 64-bit Avalon-ST packet stream tagged with a channel.

---
 rtl/eth1to4_xgmii_tx.sv | 172 +++++++++++++++++
 tb/tb_eth1to4_xgmii_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/eth1to4_xgmii_tx.sv
// Steers a channel-tagged 64-bit Avalon-ST packet stream onto one of four XGMII TX ports.
// Optional statistics counters are enabled with `define ETH1TO4_TX_STATS_EN.
module eth1to4_xgmii_tx #(
  parameter int IPG_WORDS = 2,
  parameter int NUM_PORTS = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  input  logic [2:0]  in_empty,
  input  logic [7:0]  in_channel,
  output logic [71:0] xgmii_tx_data_0_data,
  output logic [71:0] xgmii_tx_data_1_data,
  output logic [71:0] xgmii_tx_data_2_data,
  output logic [71:0] xgmii_tx_data_3_data,
  output logic        underrun
`ifdef ETH1TO4_TX_STATS_EN
  ,
  output logic [31:0] tx_pkt_count_0,
  output logic [31:0] tx_pkt_count_1,
  output logic [31:0] tx_pkt_count_2,
  output logic [31:0] tx_pkt_count_3,
  output logic [31:0] drop_count
`endif
);

  localparam logic [71:0] IDLE_W = {8{9'h107}};
  localparam logic [71:0] PRE_W  = {9'h0D5, {6{9'h055}}, 9'h1FB};
  localparam logic [71:0] TERM_W = {{7{9'h107}}, 9'h1FD};
  localparam logic [71:0] ERR_W  = {8{9'h1FE}};
  // The IDLE cycle that follows IPG supplies the last idle word, so IPG itself lasts IPG_WORDS-1 cycles.
  localparam logic [15:0] IPG_LAST = (IPG_WORDS > 1) ? 16'(IPG_WORDS - 2) : 16'd0;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_TERM, S_IPG, S_DROP} state_t;

  state_t        r_state, w_nxt, w_after_term;
  logic [1:0]    r_port;
  logic [15:0]   r_ipg_cnt;
  logic [71:0]   r_tx [NUM_PORTS];
  logic          r_underrun;
  logic [71:0]   w_word;
  logic          w_ready, w_emit, w_under, w_term, w_drop_start;

  function automatic logic [71:0] f_data_word(input logic [63:0] d, input logic eop,
                                              input logic [2:0] e);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      if (!eop || e == 3'd0 || k < 8 - int'(e)) w[9*k +: 9] = {1'b0, d[63-8*k -: 8]};
      else if (k == 8 - int'(e))                w[9*k +: 9] = 9'h1FD;
      else                                       w[9*k +: 9] = 9'h107;
    end
    return w;
  endfunction

  assign w_after_term = (IPG_WORDS > 1) ? S_IPG : S_IDLE;

  always_comb begin
    w_nxt        = r_state;
    w_ready      = 1'b0;
    w_word       = IDLE_W;
    w_emit       = 1'b0;
    w_under      = 1'b0;
    w_term       = 1'b0;
    w_drop_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (in_startofpacket) begin
            if (in_channel[7:2] != 6'd0) begin
              w_nxt        = S_DROP;
              w_drop_start = 1'b1;
            end else begin
              w_nxt = S_PRE;
            end
          end else begin
            w_ready = 1'b1;
          end
        end
      end
      S_PRE: begin
        w_emit = 1'b1;
        w_word = PRE_W;
        w_nxt  = S_DATA;
      end
      S_DATA: begin
        w_ready = 1'b1;
        w_emit  = 1'b1;
        if (in_valid) begin
          w_word = f_data_word(in_data, in_endofpacket, in_empty);
          if (in_endofpacket) begin
            if (in_empty != 3'd0) begin
              w_term = 1'b1;
              w_nxt  = w_after_term;
            end else begin
              w_nxt = S_TERM;
            end
          end
        end else begin
          w_word  = ERR_W;
          w_under = 1'b1;
        end
      end
      S_TERM: begin
        w_emit = 1'b1;
        w_word = TERM_W;
        w_term = 1'b1;
        w_nxt  = w_after_term;
      end
      S_IPG: begin
        if (r_ipg_cnt == IPG_LAST) w_nxt = S_IDLE;
      end
      S_DROP: begin
        w_ready = 1'b1;
        if (in_valid && in_endofpacket) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state    <= S_IDLE;
      r_underrun <= 1'b0;
      r_ipg_cnt  <= '0;
      for (int p = 0; p < NUM_PORTS; p++) r_tx[p] <= IDLE_W;
    end else begin
      r_state    <= w_nxt;
      r_underrun <= r_underrun | w_under;
      r_ipg_cnt  <= (r_state == S_IPG) ? r_ipg_cnt + 16'd1 : 16'd0;
      for (int p = 0; p < NUM_PORTS; p++)
        r_tx[p] <= (w_emit && r_port == 2'(p)) ? w_word : IDLE_W;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (r_state == S_IDLE) r_port <= in_channel[1:0];
  end

`ifdef ETH1TO4_TX_STATS_EN
  logic [31:0] r_pkt_cnt [NUM_PORTS];
  logic [31:0] r_drop_cnt;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_drop_cnt <= '0;
      for (int p = 0; p < NUM_PORTS; p++) r_pkt_cnt[p] <= '0;
    end else begin
      if (w_drop_start) r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_term)       r_pkt_cnt[r_port] <= r_pkt_cnt[r_port] + 32'd1;
    end
  end

  assign tx_pkt_count_0 = r_pkt_cnt[0];
  assign tx_pkt_count_1 = r_pkt_cnt[1];
  assign tx_pkt_count_2 = r_pkt_cnt[2];
  assign tx_pkt_count_3 = r_pkt_cnt[3];
  assign drop_count     = r_drop_cnt;
`endif

  assign in_ready             = w_ready;
  assign underrun             = r_underrun;
  assign xgmii_tx_data_0_data = r_tx[0];
  assign xgmii_tx_data_1_data = r_tx[1];
  assign xgmii_tx_data_2_data = r_tx[2];
  assign xgmii_tx_data_3_data = r_tx[3];

endmodule

// File: tb/tb_eth1to4_xgmii_tx.sv
// Directed, table-driven bench for eth1to4_xgmii_tx (default build, IPG_WORDS=2).
module tb_eth1to4_xgmii_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic        in_valid, in_ready, in_sop, in_eop, underrun;
  logic [2:0]  in_empty;
  logic [7:0]  in_channel;
  logic [71:0] tx0, tx1, tx2, tx3;

  always #5 clk = ~clk;

  eth1to4_xgmii_tx #(.IPG_WORDS(2)) dut (
    .clk_clk(clk), .reset_reset(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop),
    .in_empty(in_empty), .in_channel(in_channel),
    .xgmii_tx_data_0_data(tx0), .xgmii_tx_data_1_data(tx1),
    .xgmii_tx_data_2_data(tx2), .xgmii_tx_data_3_data(tx3),
    .underrun(underrun)
  );

  localparam logic [71:0] IDLE  = {8{9'h107}};
  localparam logic [71:0] PRE   = {9'h0D5, 9'h055, 9'h055, 9'h055, 9'h055, 9'h055, 9'h055, 9'h1FB};
  localparam logic [71:0] TERMW = {9'h107, 9'h107, 9'h107, 9'h107, 9'h107, 9'h107, 9'h107, 9'h1FD};
  localparam logic [71:0] ERRW  = {8{9'h1FE}};
  // Hand-built terminated words: A1..A5 then /T/ (empty=3); C0 then /T/ (empty=7).
  localparam logic [71:0] T2 = {9'h107, 9'h107, 9'h1FD, 9'h0A5, 9'h0A4, 9'h0A3, 9'h0A2, 9'h0A1};
  localparam logic [71:0] TZ = {9'h107, 9'h107, 9'h107, 9'h107, 9'h107, 9'h107, 9'h1FD, 9'h0C0};

  typedef struct {
    logic v, sop, eop;
    logic [2:0] emp;
    logic [7:0] ch;
    logic [63:0] d;
    logic rdy;
    int port;
    logic [71:0] w;
    logic un;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [71:0] dw(input logic [63:0] d);
    logic [71:0] w;
    for (int k = 0; k < 8; k++) w[9*k +: 9] = {1'b0, d[63-8*k -: 8]};
    return w;
  endfunction

  function automatic void add(input logic v, input logic sop, input logic eop,
                              input logic [2:0] emp, input logic [7:0] ch,
                              input logic [63:0] d, input logic rdy, input int port,
                              input logic [71:0] w, input logic un);
    vec_t r;
    r.v = v; r.sop = sop; r.eop = eop; r.emp = emp; r.ch = ch; r.d = d;
    r.rdy = rdy; r.port = port; r.w = w; r.un = un;
    tbl.push_back(r);
  endfunction

  function automatic logic [71:0] port_out(input int p);
    case (p)
      0: return tx0;
      1: return tx1;
      2: return tx2;
      default: return tx3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input int port,
                         input logic [71:0] w, input logic un);
    chk({tag, " in_ready"}, {71'd0, in_ready}, {71'd0, rdy});
    chk({tag, " underrun"}, {71'd0, underrun}, {71'd0, un});
    for (int p = 0; p < 4; p++)
      chk($sformatf("%s port%0d", tag, p), port_out(p), (p == port) ? w : IDLE);
  endtask

  task automatic drive(input logic v, input logic sop, input logic eop, input logic [2:0] emp,
                       input logic [7:0] ch, input logic [63:0] d);
    in_valid = v; in_sop = sop; in_eop = eop; in_empty = emp; in_channel = ch; in_data = d;
  endtask

  initial begin
    logic [63:0] d0, d1, d2, x, y, z, dd, p, q, r;
    d0 = 64'h0011223344556677; d1 = 64'h8899AABBCCDDEEFF; d2 = 64'hA1A2A3A4A5A6A7A8;
    x  = 64'h0102030405060708; y  = 64'h1112131415161718; z  = 64'hC0FFEE0000000000;
    dd = 64'hDEADBEEF00000000;
    p  = 64'h3031323334353637; q  = 64'h4041424344454647; r  = 64'h5051525354555657;

    // 3-beat packet to port 2, empty=3
    add(1,1,0,0,8'h02,d0, 0,4,IDLE,0);
    add(1,1,0,0,8'h02,d0, 0,4,IDLE,0);
    add(1,1,0,0,8'h02,d0, 1,2,PRE,0);
    add(1,0,0,0,8'h02,d1, 1,2,dw(d0),0);
    add(1,0,1,3,8'h02,d2, 1,2,dw(d1),0);
    add(0,0,0,0,8'h00,0,  0,2,T2,0);
    add(0,0,0,0,8'h00,0,  0,4,IDLE,0);
    add(0,0,0,0,8'h00,0,  0,4,IDLE,0);
    // single beat to port 0, next SOP held through IPG, then back-to-back on port 1
    add(1,1,1,0,8'h00,x, 0,4,IDLE,0);
    add(1,1,1,0,8'h00,x, 0,4,IDLE,0);
    add(1,1,1,0,8'h00,x, 1,0,PRE,0);
    add(1,1,1,0,8'h01,y, 0,0,dw(x),0);
    add(1,1,1,0,8'h01,y, 0,0,TERMW,0);
    add(1,1,1,0,8'h01,y, 0,4,IDLE,0);
    add(1,1,1,0,8'h01,y, 0,4,IDLE,0);
    add(1,1,1,0,8'h01,y, 1,1,PRE,0);
    add(1,1,1,7,8'h01,z, 0,1,dw(y),0);
    add(1,1,1,7,8'h01,z, 0,1,TERMW,0);
    add(1,1,1,7,8'h01,z, 0,4,IDLE,0);
    add(1,1,1,7,8'h01,z, 0,4,IDLE,0);
    add(1,1,1,7,8'h01,z, 1,1,PRE,0);
    add(0,0,0,0,8'h00,0, 0,1,TZ,0);
    add(0,0,0,0,8'h00,0, 0,4,IDLE,0);
    add(0,0,0,0,8'h00,0, 0,4,IDLE,0);
    // invalid channel 0x05: 4 beats dropped; then a stray non-SOP beat in IDLE
    add(1,1,0,0,8'h05,dd,   0,4,IDLE,0);
    add(1,1,0,0,8'h05,dd,   1,4,IDLE,0);
    add(1,0,0,0,8'h05,dd+1, 1,4,IDLE,0);
    add(1,0,0,0,8'h05,dd+2, 1,4,IDLE,0);
    add(1,0,1,2,8'h05,dd+3, 1,4,IDLE,0);
    add(0,0,0,0,8'h00,0,    0,4,IDLE,0);
    add(1,0,0,0,8'h03,dd,   1,4,IDLE,0);
    add(0,0,0,0,8'h00,0,    0,4,IDLE,0);
    // port 3 with a one-cycle valid gap mid-packet
    add(1,1,0,0,8'h03,p, 0,4,IDLE,0);
    add(1,1,0,0,8'h03,p, 0,4,IDLE,0);
    add(1,1,0,0,8'h03,p, 1,3,PRE,0);
    add(0,0,0,0,8'h03,0, 1,3,dw(p),0);
    add(1,0,0,0,8'h03,q, 1,3,ERRW,1);
    add(1,0,1,0,8'h03,r, 1,3,dw(q),1);
    add(0,0,0,0,8'h00,0, 0,3,dw(r),1);
    add(0,0,0,0,8'h00,0, 0,3,TERMW,1);
    add(0,0,0,0,8'h00,0, 0,4,IDLE,1);

    rst = 1'b1;
    drive(0,0,0,0,0,0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 1'b0, 4, IDLE, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i].v, tbl[i].sop, tbl[i].eop, tbl[i].emp, tbl[i].ch, tbl[i].d);
      @(negedge clk);
      chk_all($sformatf("row%0d", i), tbl[i].rdy, tbl[i].port, tbl[i].w, tbl[i].un);
    end

    // reset mid-packet: no terminate, all idle, underrun cleared
    @(posedge clk); #1 drive(1,1,0,0,8'h02,p);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all("midpkt", 1'b1, 2, dw(p), 1'b1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_all("midrst", 1'b0, 4, IDLE, 1'b0);
    rst = 1'b0;
    drive(0,0,0,0,0,0);
    @(posedge clk); @(negedge clk);
    chk_all("postrst", 1'b0, 4, IDLE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
